// File: rtl/fetch_sequencer_if.sv
// Fetch-sequencer bus: stall/redirect requests from later stages and PC/NOP controls back to fetch.
// FETCH_SEQ_PERF_EN adds the stall-cycle and redirect performance counters.
interface fetch_sequencer_if #(
   parameter int unsigned CNT_W = 5
);
   logic              hazard_stall;
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic [31:0]       seq_pc;
   logic              mc_start;
   logic [CNT_W-1:0]  mc_cycles;
   logic              halt_req;
   logic              resume;
   logic              pc_enable;
   logic [31:0]       next_pc;
   logic              inject_nop;
   logic              busy;
   logic [1:0]        state_out;
`ifdef FETCH_SEQ_PERF_EN
   logic [31:0]       stall_cycles_out;
   logic [31:0]       redirect_count_out;

   modport master (
      output hazard_stall, redirect_valid, redirect_pc, seq_pc, mc_start, mc_cycles, halt_req, resume,
      input  pc_enable, next_pc, inject_nop, busy, state_out, stall_cycles_out, redirect_count_out
   );
   modport slave (
      input  hazard_stall, redirect_valid, redirect_pc, seq_pc, mc_start, mc_cycles, halt_req, resume,
      output pc_enable, next_pc, inject_nop, busy, state_out, stall_cycles_out, redirect_count_out
   );
`else
   modport master (
      output hazard_stall, redirect_valid, redirect_pc, seq_pc, mc_start, mc_cycles, halt_req, resume,
      input  pc_enable, next_pc, inject_nop, busy, state_out
   );
   modport slave (
      input  hazard_stall, redirect_valid, redirect_pc, seq_pc, mc_start, mc_cycles, halt_req, resume,
      output pc_enable, next_pc, inject_nop, busy, state_out
   );
`endif
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: arbitrates halt, redirect, hazard and multi-cycle stalls into PC-enable/next-PC/NOP.
// Optional FETCH_SEQ_PERF_EN adds saturating stall-cycle and accepted-redirect counters.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC    = 32'h0040_0000,
   parameter int unsigned FLUSH_SLOTS = 1,
   parameter int unsigned CNT_W       = 5
) (
   input  logic           clk,
   input  logic           reset,
   fetch_sequencer_if.slave bus
);
   typedef enum logic [1:0] {
      RUN    = 2'd0,
      FLUSH  = 2'd1,
      MCWAIT = 2'd2,
      HALT   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_SLOTS);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam bit               HAS_FLUSH  = (FLUSH_SLOTS != 0);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             pc_en, nop, redirect_taken;
   logic [31:0]      npc;

   // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_nx       = state;
      cnt_nx         = cnt;
      pc_en          = 1'b1;
      nop            = 1'b0;
      npc            = bus.seq_pc;
      redirect_taken = 1'b0;
      unique case (state)
         RUN: begin
            if (bus.halt_req) begin
               pc_en    = 1'b0;
               nop      = 1'b1;
               state_nx = HALT;
            end else if (bus.redirect_valid) begin
               npc            = bus.redirect_pc;
               redirect_taken = 1'b1;
               if (HAS_FLUSH) begin
                  cnt_nx   = FLUSH_LOAD;
                  state_nx = FLUSH;
               end
            end else if (bus.hazard_stall) begin
               pc_en = 1'b0;
               nop   = 1'b1;
            end else if (bus.mc_start && (bus.mc_cycles != '0)) begin
               cnt_nx   = bus.mc_cycles;
               state_nx = MCWAIT;
            end
         end
         FLUSH: begin
            if (bus.halt_req) begin
               pc_en    = 1'b0;
               nop      = 1'b1;
               cnt_nx   = '0;
               state_nx = HALT;
            end else if (bus.redirect_valid) begin
               npc            = bus.redirect_pc;
               redirect_taken = 1'b1;
               cnt_nx         = FLUSH_LOAD;
            end else begin
               nop = 1'b1;
               if (cnt != '0) cnt_nx = cnt - CNT_ONE;
               if (cnt <= CNT_ONE) state_nx = RUN;
            end
         end
         MCWAIT: begin
            // Later-stage requests are deliberately deaf here; a held halt_req is seen once back in RUN.
            pc_en = 1'b0;
            nop   = 1'b1;
            if (cnt != '0) cnt_nx = cnt - CNT_ONE;
            if (cnt <= CNT_ONE) state_nx = RUN;
         end
         HALT: begin
            pc_en = 1'b0;
            nop   = 1'b1;
            if (bus.resume && !bus.halt_req) state_nx = RUN;
         end
         default: state_nx = RUN;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Reset overrides the decode combinationally so the PC mux sees RESET_PC while reset is held.
   assign bus.pc_enable  = reset & pc_en;
   assign bus.inject_nop = ~reset | nop;
   assign bus.next_pc    = reset ? npc : RESET_PC;
   assign bus.busy       = reset & (state != RUN);
   assign bus.state_out  = state;

`ifdef FETCH_SEQ_PERF_EN
   logic [31:0] stall_cycles, redirect_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cycles   <= '0;
         redirect_count <= '0;
      end else begin
         if (!pc_en && (stall_cycles != '1))            stall_cycles   <= stall_cycles + 32'd1;
         if (redirect_taken && (redirect_count != '1)) redirect_count <= redirect_count + 32'd1;
      end
   end

   assign bus.stall_cycles_out   = stall_cycles;
   assign bus.redirect_count_out = redirect_count;
`else
   logic unused_redirect;
   assign unused_redirect = redirect_taken;
`endif
endmodule
